// File: rtl/ez8_loader_pkg.sv
// ez8_loader_pkg: shared types and constants for the ez8 program loader.
//   state_t   - frame parser state encoding
//   ERR_*     - err_code values reported to the host
//   MAX_WORDS - largest legal frame length in words
package ez8_loader_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MAX_WORDS = 4095;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN_H = 3'd1,
        LEN_L = 3'd2,
        D_HI  = 3'd3,
        D_LO  = 3'd4,
        CHK   = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // States in which a frame is being received.
    function automatic logic in_frame(input state_t s);
        return (s == LEN_H) || (s == LEN_L) || (s == D_HI) || (s == D_LO) || (s == CHK);
    endfunction

endpackage

// File: rtl/ez8_loader_timer.sv
// ez8_loader_timer: inter-byte idle counter.
//   clk, reset   - clock, synchronous active-high reset
//   i_clear      - a byte was accepted this cycle (clears the count)
//   i_enable     - counting allowed (frame in progress); count frozen otherwise
//   o_expired_c  - this idle cycle is the TIMEOUT-th in a row (combinational)
module ez8_loader_timer #(
    parameter int unsigned TIMEOUT   = 20000,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] r_count;

    // Counts consecutive idle cycles; an accepted byte always restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

    // A byte in the same cycle wins over the timeout.
    assign o_expired_c = (TIMEOUT != 0) && i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/ez8_loader.sv
// ez8_loader: framed byte-stream loader for the ez8 instruction memory.
//   Frame: MAGIC, LEN_HI, LEN_LO, LEN x {hi, lo}, CHK (mod-256 sum of data bytes).
//   clk, reset        - clock, synchronous active-high reset
//   rx_data/rx_valid  - incoming byte stream, no backpressure
//   instr_write*      - registered instruction memory write port
//   cpu_reset         - holds the CPU in reset while not in IDLE
//   load_ok           - last frame verified, CPU released
//   busy              - frame in progress
//   err_code          - 0 none, 1 bad length, 2 checksum, 3 timeout
module ez8_loader
    import ez8_loader_pkg::*;
#(
    parameter logic [7:0]  MAGIC     = 8'hE8,
    parameter int unsigned TIMEOUT   = 20000,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] instr_writeaddr,
    output logic [DATA_W-1:0] instr_writedata,
    output logic              instr_write_en,
    output logic              cpu_reset,
    output logic              load_ok,
    output logic              busy,
    output logic [1:0]        err_code
);

    state_t            r_state;
    logic [7:0]        r_len_hi;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_sum;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_cpu_reset;
    logic              r_load_ok;
    logic              r_busy;
    logic [1:0]        r_err;

    logic              w_expired;
    logic [15:0]       w_len16;
    logic              w_len_bad;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_len16    = {r_len_hi, rx_data};
    assign w_len_bad  = (w_len16 == 16'd0) || (w_len16 > 16'(MAX_WORDS));
    assign w_addr_inc = r_addr + ADDR_W'(1);

    ez8_loader_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (rx_valid),
        .i_enable    (in_frame(r_state)),
        .o_expired_c (w_expired)
    );

    // Frame parser; outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_len_hi    <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_sum       <= '0;
            r_hi        <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_load_ok   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= ERR_NONE;
        end else begin
            r_we        <= 1'b0;
            r_cpu_reset <= (r_state != IDLE);
            if (rx_valid) begin
                case (r_state)
                    IDLE, ERROR: begin
                        if (rx_data == MAGIC) begin
                            r_state     <= LEN_H;
                            r_busy      <= 1'b1;
                            r_cpu_reset <= 1'b1;
                            r_load_ok   <= 1'b0;
                            r_err       <= ERR_NONE;
                            r_addr      <= '0;
                            r_sum       <= '0;
                        end
                    end
                    LEN_H: begin
                        r_len_hi <= rx_data;
                        r_state  <= LEN_L;
                    end
                    LEN_L: begin
                        if (w_len_bad) begin
                            r_state <= ERROR;
                            r_err   <= ERR_LEN;
                            r_busy  <= 1'b0;
                        end else begin
                            r_len   <= w_len16[ADDR_W-1:0];
                            r_state <= D_HI;
                        end
                    end
                    D_HI: begin
                        r_hi    <= rx_data;
                        r_sum   <= r_sum + rx_data;
                        r_state <= D_LO;
                    end
                    D_LO: begin
                        r_sum   <= r_sum + rx_data;
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= {r_hi, rx_data};
                        r_addr  <= w_addr_inc;
                        r_state <= (w_addr_inc == r_len) ? CHK : D_HI;
                    end
                    CHK: begin
                        r_busy <= 1'b0;
                        if (rx_data == r_sum) begin
                            r_state     <= IDLE;
                            r_cpu_reset <= 1'b0;
                            r_load_ok   <= 1'b1;
                        end else begin
                            r_state <= ERROR;
                            r_err   <= ERR_CHK;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (w_expired) begin
                r_state <= ERROR;
                r_err   <= ERR_TMO;
                r_busy  <= 1'b0;
            end
        end
    end

    assign instr_writeaddr = r_waddr;
    assign instr_writedata = r_wdata;
    assign instr_write_en  = r_we;
    assign cpu_reset       = r_cpu_reset;
    assign load_ok         = r_load_ok;
    assign busy            = r_busy;
    assign err_code        = r_err;

endmodule

// File: tb/tb_ez8_loader.sv
// tb_ez8_loader: directed test of the ez8 loader with hand-computed expectations.
module tb_ez8_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] instr_writeaddr;
    logic [15:0] instr_writedata;
    logic        instr_write_en;
    logic        cpu_reset;
    logic        load_ok;
    logic        busy;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    logic [27:0] wq[$];

    ez8_loader #(
        .MAGIC     (8'hE8),
        .TIMEOUT   (8),
        .TIMEOUT_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .instr_writeaddr (instr_writeaddr),
        .instr_writedata (instr_writedata),
        .instr_write_en  (instr_write_en),
        .cpu_reset       (cpu_reset),
        .load_ok         (load_ok),
        .busy            (busy),
        .err_code        (err_code)
    );

    always #5 clk = ~clk;

    // Log every write strobe as {addr, data}.
    always @(negedge clk) begin
        if (instr_write_en) wq.push_back({instr_writeaddr, instr_writedata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input logic [7:0] b[$]);
        foreach (b[i]) send(b[i]);
    endtask

    task automatic check_wq(input string tag, input int idx, input logic [27:0] exp);
        if (idx < wq.size()) check(tag, 32'(wq[idx]), 32'(exp));
        else check(tag, 32'hDEAD_BEEF, 32'(exp));
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(2);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_we", 32'(instr_write_en), 32'd0);
        check("rst_addr", 32'(instr_writeaddr), 32'd0);
        check("rst_data", 32'(instr_writedata), 32'd0);
        check("rst_outs", 32'({load_ok, busy, err_code}), 32'd0);
        reset = 1'b0;
        idle(1);
        check("rst_release_cpu", 32'(cpu_reset), 32'd0);

        // Good 2-word frame: 12+34+AB+CD = 1BE -> BE.
        wq.delete();
        send(8'hE8);
        check("good_magic_busy", 32'({busy, cpu_reset}), 32'b11);
        send_seq('{8'h00, 8'h02, 8'h12, 8'h34});
        check("good_w0_strobe", 32'({instr_write_en, instr_writeaddr, instr_writedata}), 32'({1'b1, 12'h000, 16'h1234}));
        send_seq('{8'hAB, 8'hCD});
        check("good_w1_strobe", 32'({instr_write_en, instr_writeaddr, instr_writedata}), 32'({1'b1, 12'h001, 16'hABCD}));
        send(8'hBE);
        check("good_we_low", 32'(instr_write_en), 32'd0);
        check("good_status", 32'({cpu_reset, load_ok, busy, err_code}), 32'b0_1_0_00);
        check("good_nwrites", 32'(wq.size()), 32'd2);
        check_wq("good_wq0", 0, {12'h000, 16'h1234});
        check_wq("good_wq1", 1, {12'h001, 16'hABCD});

        // Bad checksum, then recovery.
        wq.delete();
        send_seq('{8'hE8, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF});
        idle(2);
        check("badchk_status", 32'({cpu_reset, load_ok, busy, err_code}), 32'b1_0_0_10);
        check("badchk_nwrites", 32'(wq.size()), 32'd2);
        check_wq("badchk_wq1", 1, {12'h001, 16'hABCD});
        send_seq('{8'hE8, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE});
        check("recover_status", 32'({cpu_reset, load_ok, busy, err_code}), 32'b0_1_0_00);

        // Bad lengths 0 and 4096.
        wq.delete();
        send_seq('{8'hE8, 8'h00, 8'h00});
        check("len0_status", 32'({cpu_reset, load_ok, busy, err_code}), 32'b1_0_0_01);
        send_seq('{8'hE8, 8'h10, 8'h00});
        check("len4096_status", 32'({cpu_reset, load_ok, busy, err_code}), 32'b1_0_0_01);
        check("badlen_nwrites", 32'(wq.size()), 32'd0);

        // 4095 is legal; abandon it and let the timeout fire.
        send_seq('{8'hE8, 8'h0F, 8'hFF});
        check("len4095_busy", 32'({busy, err_code}), 32'b1_00);
        idle(10);
        check("len4095_tmo", 32'({busy, err_code}), 32'b0_11);

        // Timeout after the high byte: still busy after 7 idle cycles, error on the 8th.
        wq.delete();
        send_seq('{8'hE8, 8'h00, 8'h01, 8'h12});
        idle(7);
        check("tmo_before", 32'({busy, err_code}), 32'b1_00);
        idle(1);
        check("tmo_fired", 32'({cpu_reset, busy, err_code}), 32'b1_0_11);
        send(8'h34);
        idle(2);
        check("tmo_late_nowrite", 32'(wq.size()), 32'd0);
        check("tmo_held", 32'(err_code), 32'd3);

        // MAGIC as data: E8+E8 = 1D0 -> D0.
        send_seq('{8'hE8, 8'h00, 8'h01, 8'hE8, 8'hE8, 8'hD0});
        check("magicdata_status", 32'({cpu_reset, load_ok, busy, err_code}), 32'b0_1_0_00);
        check_wq("magicdata_wq0", 0, {12'h000, 16'hE8E8});

        // Junk bytes in IDLE are ignored.
        send_seq('{8'h00, 8'hFF, 8'h55});
        idle(1);
        check("idle_junk", 32'({cpu_reset, load_ok, busy, err_code}), 32'b0_1_0_00);

        // Reset after the high byte of word 3 of a 4-word frame.
        wq.delete();
        send_seq('{8'hE8, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
        check("midrst_nwrites_pre", 32'(wq.size()), 32'd2);
        wq.delete();
        reset    = 1'b1;
        rx_data  = 8'h66;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("midrst_outs", 32'({instr_write_en, instr_writeaddr, instr_writedata, cpu_reset, load_ok, busy, err_code}),
              32'({1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00}));
        reset = 1'b0;
        idle(1);
        check("midrst_release", 32'(cpu_reset), 32'd0);
        send_seq('{8'h77, 8'h88, 8'h99});
        idle(2);
        check("midrst_nowrite", 32'(wq.size()), 32'd0);
        check("midrst_idle", 32'({cpu_reset, busy, err_code}), 32'b0_0_00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
